alu_operand_stage: RTL and testbench

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

---
 rtl/alu_operand_stage_pkg.sv | 26 ++
 rtl/alu_operand_stage_if.sv | 32 +++
 rtl/alu_operand_stage_reg32.sv | 17 +
 rtl/alu_operand_stage.sv | 68 ++++++
 tb/tb_alu_operand_stage.sv | 137 +++++++++++++
 5 files changed

// File: rtl/alu_operand_stage_pkg.sv
// rtl/alu_operand_stage_pkg.sv - shared constants for the ALU operand stage
package alu_operand_stage_pkg;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int FLAG_W   = 4;

  // flags vector is {negative, carryout, overflow, zero}
  localparam int FLAG_ZERO     = 0;
  localparam int FLAG_OVERFLOW = 1;
  localparam int FLAG_CARRY    = 2;
  localparam int FLAG_NEGATIVE = 3;

  typedef enum logic [2:0] {
    OP_NOP   = 3'd0,
    OP_ADD   = 3'd1,
    OP_SUB   = 3'd2,
    OP_AND   = 3'd3,
    OP_OR    = 3'd4,
    OP_XOR   = 3'd5,
    OP_CMP   = 3'd6,
    OP_SHIFT = 3'd7
  } opcode_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// rtl/alu_operand_stage_if.sv - issue, write-back, flag and operand signals of the stage
interface alu_operand_stage_if;
  import alu_operand_stage_pkg::*;

  logic [ADDR_W-1:0] readAddrA;
  logic [ADDR_W-1:0] readAddrB;
  logic [2:0]        controlIn;
  logic              validIn;
  logic [ADDR_W-1:0] writeAddr;
  logic [DATA_W-1:0] writeData;
  logic              writeEnable;
  logic [FLAG_W-1:0] flagsIn;
  logic              flagsEnable;
  logic [DATA_W-1:0] busA;
  logic [DATA_W-1:0] busB;
  logic [2:0]        control;
  logic              validOut;
  logic [FLAG_W-1:0] flags;

  modport master (
    output readAddrA, readAddrB, controlIn, validIn,
    output writeAddr, writeData, writeEnable, flagsIn, flagsEnable,
    input  busA, busB, control, validOut, flags
  );

  modport slave (
    input  readAddrA, readAddrB, controlIn, validIn,
    input  writeAddr, writeData, writeEnable, flagsIn, flagsEnable,
    output busA, busB, control, validOut, flags
  );

endinterface

// File: rtl/alu_operand_stage_reg32.sv
// rtl/alu_operand_stage_reg32.sv - 32-bit register with synchronous reset and load enable
module reg32
  import alu_operand_stage_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [DATA_W-1:0] d,
  output logic [DATA_W-1:0] q
);

  always_ff @(posedge clk) begin
    if (rst)       q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/alu_operand_stage.sv
// rtl/alu_operand_stage.sv - register file with write-through bypass feeding registered ALU operands
module alu_operand_stage
  import alu_operand_stage_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  alu_operand_stage_if.slave   bus
);

  logic [DATA_W-1:0] entry_q [NUM_REGS];
  logic [DATA_W-1:0] opnd_a;
  logic [DATA_W-1:0] opnd_b;
  logic              wr_live;

  assign entry_q[0] = '0;

  genvar i;
  generate
    for (i = 1; i < NUM_REGS; i++) begin : g_entry
      reg32 u_entry (
        .clk  (clk),
        .rst  (rst),
        .load (bus.writeEnable && (bus.writeAddr == ADDR_W'(i))),
        .d    (bus.writeData),
        .q    (entry_q[i])
      );
    end
  endgenerate

  // A write to r0 is discarded, so it must not forward either
  assign wr_live = bus.writeEnable && (bus.writeAddr != '0);

  always_comb begin
    opnd_a = entry_q[bus.readAddrA];
    opnd_b = entry_q[bus.readAddrB];
    if (wr_live && (bus.writeAddr == bus.readAddrA)) opnd_a = bus.writeData;
    if (wr_live && (bus.writeAddr == bus.readAddrB)) opnd_b = bus.writeData;
  end

  reg32 u_bus_a (
    .clk  (clk),
    .rst  (rst),
    .load (bus.validIn),
    .d    (opnd_a),
    .q    (bus.busA)
  );

  reg32 u_bus_b (
    .clk  (clk),
    .rst  (rst),
    .load (bus.validIn),
    .d    (opnd_b),
    .q    (bus.busB)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.control  <= '0;
      bus.validOut <= 1'b0;
      bus.flags    <= '0;
    end else begin
      bus.validOut <= bus.validIn;
      if (bus.validIn)     bus.control <= bus.controlIn;
      if (bus.flagsEnable) bus.flags   <= bus.flagsIn;
    end
  end

endmodule

// File: tb/tb_alu_operand_stage.sv
// tb/tb_alu_operand_stage.sv - scoreboard bench for alu_operand_stage
module tb_alu_operand_stage;
  import alu_operand_stage_pkg::*;

  logic clk;
  logic rst;

  alu_operand_stage_if ifc ();

  alu_operand_stage dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  c;
    logic        v;
    logic [3:0]  f;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem [32];
  exp_t        cur;
  int          n_chk;
  int          n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit r, input bit v, input logic [4:0] ra, input logic [4:0] rb,
                      input logic [2:0] c, input bit we, input logic [4:0] wa,
                      input logic [31:0] wd, input bit fe, input logic [3:0] fi);
    exp_t got;
    rst             = r;
    ifc.validIn     = v;
    ifc.readAddrA   = ra;
    ifc.readAddrB   = rb;
    ifc.controlIn   = c;
    ifc.writeEnable = we;
    ifc.writeAddr   = wa;
    ifc.writeData   = wd;
    ifc.flagsEnable = fe;
    ifc.flagsIn     = fi;
    if (r) begin
      foreach (mem[k]) mem[k] = '0;
      cur.a = '0; cur.b = '0; cur.c = '0; cur.v = 1'b0; cur.f = '0;
    end else begin
      cur.v = v;
      if (v) begin
        cur.a = (we && wa != 0 && wa == ra) ? wd : mem[ra];
        cur.b = (we && wa != 0 && wa == rb) ? wd : mem[rb];
        cur.c = c;
      end
      if (we && wa != 0) mem[wa] = wd;
      if (fe) cur.f = fi;
    end
    sb.push_back(cur);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      got = sb.pop_front();
      chk("busA",     ifc.busA,            got.a);
      chk("busB",     ifc.busB,            got.b);
      chk("control",  32'(ifc.control),    32'(got.c));
      chk("validOut", 32'(ifc.validOut),   32'(got.v));
      chk("flags",    32'(ifc.flags),      32'(got.f));
    end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    foreach (mem[k]) mem[k] = '0;
    cur = '{a: '0, b: '0, c: '0, v: 1'b0, f: '0};

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset clears regfile and dominates every strobe
    step(0, 0, 0, 0, 0, 1, 5, 32'hDEADBEEF, 1, 4'hF);
    step(0, 1, 5, 5, OP_XOR, 0, 0, 0, 0, 0);
    step(1, 1, 5, 5, OP_ADD, 1, 5, 32'h12345678, 1, 4'h9);
    step(0, 1, 5, 5, OP_SUB, 0, 0, 0, 0, 0);

    // basic read with one-cycle latency
    step(0, 0, 0, 0, 0, 1, 3, 32'h00000007, 0, 0);
    step(0, 0, 0, 0, 0, 1, 4, 32'h00000009, 0, 0);
    step(0, 1, 3, 4, OP_ADD, 0, 0, 0, 0, 0);

    // same-edge write bypass to both operands
    step(0, 0, 0, 0, 0, 1, 6, 32'h11111111, 0, 0);
    step(0, 1, 6, 6, OP_AND, 1, 6, 32'h22222222, 0, 0);
    step(0, 1, 6, 3, OP_OR, 0, 0, 0, 0, 0);

    // r0 is hardwired to zero and never forwards
    step(0, 1, 0, 4, OP_CMP, 1, 0, 32'hFFFFFFFF, 0, 0);
    step(0, 1, 0, 0, OP_SHIFT, 0, 0, 0, 0, 0);

    // hold operands while idle, writes continue underneath
    step(0, 1, 3, 3, OP_SUB, 0, 0, 0, 0, 0);
    step(0, 0, 9, 9, OP_NOP, 1, 3, 32'h00000005, 0, 0);
    step(0, 0, 9, 9, OP_NOP, 1, 3, 32'h00000005, 0, 0);
    step(0, 0, 9, 9, OP_NOP, 1, 3, 32'h00000005, 0, 0);
    step(0, 1, 3, 31, OP_ADD, 1, 31, 32'hCAFEF00D, 0, 0);

    // flags capture and hold
    step(0, 0, 0, 0, 0, 0, 0, 0, 1, 4'b1010);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b0101);

    // random traffic over a narrow address window to exercise bypass often
    for (int n = 0; n < 400; n++) begin
      step(($urandom_range(0, 63) == 0), $urandom_range(0, 1),
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom),
           $urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 1), 4'($urandom));
    end

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
